// File: rtl/div32_seq.sv
// Iterative radix-2 restoring divider, signed/unsigned, start/busy/done handshake.
// Optional early exit for trivial operands is enabled with `define DIV32_EARLY_OUT_EN.
module div32_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  input  logic             alu_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_dvd_raw;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;
  logic             r_ovf;

  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic             w_ovf_case;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Operand magnitudes and the special-case detect, evaluated on the live inputs at accept
  assign w_dvd_neg  = alu_signed & DIVIDEND[WIDTH-1];
  assign w_dsr_neg  = alu_signed & DIVISOR[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? WIDTH'(-DIVIDEND) : DIVIDEND;
  assign w_dsr_mag  = w_dsr_neg ? WIDTH'(-DIVISOR) : DIVISOR;
  assign w_ovf_case = alu_signed && (DIVIDEND == {1'b1, {(WIDTH-1){1'b0}}}) && (DIVISOR == '1);

  // Remainder stays below the divisor, so a (WIDTH+1)-bit trial subtract never loses the sign
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dsr};

`ifdef DIV32_EARLY_OUT_EN
  logic w_early;
  assign w_early = (DIVISOR == '0) || (w_dvd_mag < w_dsr_mag);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dsr       <= '0;
      r_dvd_raw   <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      QUOT        <= '0;
      REM         <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rem       <= '0;
            r_quo       <= w_dvd_mag;
            r_dsr       <= w_dsr_mag;
            r_dvd_raw   <= DIVIDEND;
            r_qneg      <= w_dvd_neg ^ w_dsr_neg;
            r_rneg      <= w_dvd_neg;
            r_dz        <= (DIVISOR == '0);
            r_ovf       <= w_ovf_case;
            r_cnt       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            r_state     <= S_CALC;
`ifdef DIV32_EARLY_OUT_EN
            if (w_early) begin
              r_quo   <= '0;
              r_rem   <= w_dvd_mag;
              r_state <= S_FIX;
            end
`endif
          end
        end
        S_CALC: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
          end
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          // Divide-by-zero reports the raw dividend, bypassing sign correction
          if (r_dz) begin
            QUOT        <= '1;
            REM         <= r_dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            QUOT     <= r_qneg ? WIDTH'(-r_quo) : r_quo;
            REM      <= r_rneg ? WIDTH'(-r_rem) : r_rem;
            overflow <= r_ovf;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed and random self-checking bench for div32_seq.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic        alu_signed;
  logic        busy;
  logic        done;
  logic [31:0] QUOT;
  logic [31:0] REM;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  div32_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR), .alu_signed(alu_signed),
    .busy(busy), .done(done), .QUOT(QUOT), .REM(REM),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    int lat;
    lat = 34;
`ifdef DIV32_EARLY_OUT_EN
    begin
      logic [31:0] ma, mb;
      ma = (s && a[31]) ? -a : a;
      mb = (s && b[31]) ? -b : b;
      if (b == 32'd0 || ma < mb) lat = 2;
    end
`endif
    return lat;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with inputs scrambled
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    DIVIDEND = a; DIVISOR = b; alu_signed = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    DIVIDEND = $urandom; DIVISOR = $urandom; alu_signed = ~s;
  endtask

  // k = number of edges since, and counting, the accept edge when done is seen
  task automatic wait_done(input int glitch, output int k);
    k = 1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    while (!done && k < 200) begin
      if (k == glitch) begin
        start = 1'b1; DIVIDEND = 32'd5; DIVISOR = 32'd1; alu_signed = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k++;
    end
  endtask

  task automatic check_res(input string tag, input int k, input int lat,
                           input logic [31:0] q, input logic [31:0] r,
                           input logic dz, input logic ov);
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_quot"}, QUOT, q);
    chk({tag, "_rem"}, REM, r);
    chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, dz});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] q, input logic [31:0] r, input logic dz, input logic ov);
    int k;
    launch(a, b, s);
    wait_done(-1, k);
    check_res(tag, k, exp_lat(a, b, s), q, r, dz, ov);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Reference: language-level truncating division
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic ov);
    int sa, sb;
    sa = int'(a); sb = int'(b);
    dz = 1'b0; ov = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
    end else if (s) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  initial begin
    int k;
    logic [31:0] a, b, q, r;
    logic s, dz, ov;

    rst = 1'b1; start = 1'b0; DIVIDEND = '0; DIVISOR = '0; alu_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", QUOT, 32'd0);
    chk("rst_rem", REM, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("u100_7",   32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    run("sm100_7",  32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run("s100_m7",  32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
    run("s_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    run("u_noovf",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run("u_dz",     32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
    run("s_dz",     32'd1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
    run("s_small",  32'hFFFF_FFFD, 32'd5, 1'b1, 32'd0, 32'hFFFF_FFFD, 1'b0, 1'b0);

    // Start while busy is ignored; start in the done cycle is accepted
    launch(32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(10, k);
    check_res("ignore_start", k, 34, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    launch(32'd50, 32'd6, 1'b0);
    wait_done(-1, k);
    check_res("back2back", k, 34, 32'd8, 32'd2, 1'b0, 1'b0);
    @(negedge clk);

    // Reset mid-divide aborts without a done pulse
    launch(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quot", QUOT, 32'd0);
    chk("abort_rem", REM, 32'd0);
    chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
    chk("abort_ovf", {31'd0, overflow}, 32'd0);
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) k++;
    end
    chk("abort_no_done", k, 0);
    run("after_rst_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      ref_div(a, b, s, q, r, dz, ov);
      launch(a, b, s);
      wait_done(-1, k);
      check_res("rand", k, exp_lat(a, b, s), q, r, dz, ov);
      if (b != 32'd0) chk("rand_invariant", QUOT * b + REM, a);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Iterative 32/32 radix-2 restoring divider. It is the inverse-direction companion of the combinational 32x32 Booth multiplier in the ALU datapath.
- Takes DIVIDEND/DIVISOR plus the same alu_signed mode select and returns QUOT and REM after a fixed multi-cycle latency.
- Handshake is start/busy/done, so the ALU can stall on divide ops while multiplies stay single-cycle.

Parameters:
- WIDTH, 32, operand/result width; only 32 is required to be supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only while busy=0
- DIVIDEND  input  32  dividend, latched on accepted start
- DIVISOR  input  32  divisor, latched on accepted start
- alu_signed  input  1  1 = two's-complement divide, 0 = unsigned; latched on accepted start
- busy  output  1  high from the edge after accept until the edge that raises done
- done  output  1  one-cycle pulse; results valid when high
- QUOT  output  32  quotient, held until next accepted start
- REM  output  32  remainder, held until next accepted start
- div_by_zero  output  1  result flag, valid with done, held
- overflow  output  1  signed -2^31 / -1 flag, valid with done, held

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. busy, done, QUOT, REM, div_by_zero and overflow all go to 0. Applies mid-operation: the op is aborted with no done pulse.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 (accept edge):
  - Latch operands and mode; busy<=1; count<=0; state<=CALC.
  - Compute magnitudes: in signed mode, abs() of each negative operand; in unsigned mode, raw values.
  - Record q_neg = signed & (dividend[31]^divisor[31]) and r_neg = signed & dividend[31].
- CALC: one restoring step per cycle.
  - {rem,quo} shifted left 1; trial = rem - |divisor| using a 33-bit subtract.
  - If trial is non-negative: rem<=trial and quo LSB<=1; otherwise quo LSB<=0.
  - After the 32nd step, state<=FIX.
- FIX:
  - QUOT = q_neg ? -quo : quo; REM = r_neg ? -rem : rem.
  - done<=1 for exactly one cycle; busy<=0; state<=IDLE.
- Latency: done is high in the cycle following the 34th rising edge after, and counting, the accept edge (accept + 32 CALC + FIX). Back-to-back is allowed: start in the done cycle is accepted.
- start while busy=1 is ignored. Operand or alu_signed changes after accept have no effect.
- Divide by zero (DIVISOR=0): QUOT=0xFFFFFFFF, REM=DIVIDEND (raw, unmodified), div_by_zero=1, in both modes. Latency is as above unless the optional feature is compiled in.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): QUOT=0x80000000, REM=0, overflow=1. Falls out naturally from 33-bit magnitude arithmetic; the flag is set explicitly.
- Flags are cleared on every accepted start.
- Invariant for divisor != 0: DIVIDEND == QUOT*DIVISOR + REM (mod 2^32). |REM| < |DIVISOR|. REM is 0 or has the sign of DIVIDEND.

Optional Feature:
- Macro: DIV32_EARLY_OUT_EN.
- Defined: at the accept edge, if DIVISOR=0, or |DIVIDEND| < |DIVISOR| as unsigned magnitudes, go directly to FIX with quo=0 and rem=|dividend|; the div-by-zero result values are as specified above. done is then high in the cycle after the 2nd edge counting the accept edge; busy is high for one cycle.
- Undefined: all operations take the fixed 34-edge latency.

Test Plan:
- Unsigned 100/7, alu_signed=0 -> QUOT=14, REM=2, flags 0. done exactly one cycle, in the cycle after the 34th edge counting accept.
- Signed -100/7 -> QUOT=0xFFFFFFF2 (-14), REM=0xFFFFFFFE (-2). Signed 100/-7 -> QUOT=-14, REM=2.
- 0x80000000/0xFFFFFFFF: signed -> QUOT=0x80000000, REM=0, overflow=1. Unsigned -> QUOT=0, REM=0x80000000, overflow=0.
- 1234/0 in both modes -> QUOT=0xFFFFFFFF, REM=1234, div_by_zero=1. With DIV32_EARLY_OUT_EN, done arrives in the cycle after the 2nd edge.
- Start 0xFFFFFFFF/2 unsigned; pulse start with new operands at cycle 10 -> ignored, result QUOT=0x7FFFFFFF, REM=1. Then start in the done cycle -> accepted.
- rst=1 at cycle 15 mid-divide -> busy=0, all outputs 0, no done. Next divide 9/3 -> QUOT=3, REM=0.
- Random: 1000 operand pairs with random mode, checked against the invariant and the reference model.
